// File: rtl/pwm_sample_dac.sv
// Audio PWM output stage: a 2-entry sample FIFO feeds a free-running PWM counter.
// The duty is reloaded only at period boundaries. An empty FIFO at a boundary holds the duty and raises a sticky underrun.
module pwm_sample_dac #(
  parameter int unsigned DW        = 11,
  parameter int unsigned CW        = 11,
  parameter int unsigned IDLE_DUTY = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          pwm_out,
  output logic          period_tick,
  output logic          underrun,
  input  logic          underrun_clr,
  output logic [CW-1:0] duty_cur
);

  localparam int unsigned   SHIFT    = CW - DW;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DUTY_RST = CW'(IDLE_DUTY);
  localparam logic [1:0]    DEPTH    = 2'd2;

  if (DW > CW) begin : g_bad_width
    $error("pwm_sample_dac: DW must not exceed CW");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] fifo_q [2];
  logic [CW-1:0] fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          pwm_q, pwm_d;
  logic          underrun_q, underrun_d;
  logic          boundary;
  logic          push;
  logic          pop;

  assign sample_ready = (count_q != DEPTH);
  assign boundary     = enable && (cnt_q == CNT_MAX);
  assign push         = sample_valid && sample_ready;
  // A sample pushed on an empty boundary is not forwarded; it waits for the next one.
  assign pop          = boundary && (count_q != 2'd0);

  assign period_tick  = boundary;
  assign pwm_out      = pwm_q;
  assign underrun     = underrun_q;
  assign duty_cur     = duty_q;

  // Next-state logic for counter, FIFO, duty, underrun and PWM output.
  always_comb begin
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    underrun_d = underrun_q;
    pwm_d      = 1'b0;

    if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = CNT_MAX;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = CW'(sample_in) << SHIFT;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      duty_d   = fifo_q[rd_ptr_q];
      rd_ptr_d = ~rd_ptr_q;
    end

    count_d = count_q + 2'(push) - 2'(pop);

    // Set has priority over clear.
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (boundary && (count_q == 2'd0)) begin
      underrun_d = 1'b1;
    end

    pwm_d = enable && (cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CNT_MAX;
      duty_q     <= DUTY_RST;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pwm_sample_dac.sv
// Directed bench for pwm_sample_dac: period high counts, FIFO handshake, underrun, enable and reset behaviour.
module tb_pwm_sample_dac;

  localparam int unsigned DW  = 11;
  localparam int unsigned CW  = 11;
  localparam int          PER = 2048;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          pwm_out;
  logic          period_tick;
  logic          underrun;
  logic          underrun_clr;
  logic [CW-1:0] duty_cur;

  int n_chk;
  int n_err;

  pwm_sample_dac #(.DW(DW), .CW(CW), .IDLE_DUTY(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .duty_cur     (duty_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 4096);
    chk(tag, 32'(period_tick), 1);
  endtask

  // Starting on a tick cycle, count pwm highs over the following period; ends on the next tick.
  task automatic run_period(output int highs, output logic [CW-1:0] d_first);
    highs   = 0;
    d_first = '0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == 0) d_first = duty_cur;
      if (pwm_out) highs++;
    end
    chk("period_end_tick", 32'(period_tick), 1);
  endtask

  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] d;
  logic [CW-1:0] exp_d;
  logic [CW-1:0] last_d;
  logic [DW-1:0] data;
  logic          rdy_prev;
  logic          prev_tick;
  int            h;
  int            ticks;
  int            acc_period;
  int            guard;

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    last_d       = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_duty", 32'(duty_cur), 1024);
    chk("rst_ready", 32'(sample_ready), 1);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_tick", 32'(period_tick), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: idle duty, no samples
    enable = 1'b1;
    #1 chk("t1_first_boundary", 32'(period_tick), 1);
    run_period(h, d);
    chk("t1_high0", h, 1024);
    chk("t1_duty0", 32'(d), 1024);
    chk("t1_underrun", 32'(underrun), 1);
    run_period(h, d);
    chk("t1_high1", h, 1024);

    // 2: two queued samples
    @(negedge clk);
    clr_pulse();
    chk("t2_clr", 32'(underrun), 0);
    push(11'h200);
    chk("t2_ready_after1", 32'(sample_ready), 1);
    push(11'h600);
    chk("t2_ready_after2", 32'(sample_ready), 0);
    wait_tick("t2_tick");
    chk("t2_duty_hold_at_tick", 32'(duty_cur), 1024);
    run_period(h, d);
    chk("t2_duty_a", 32'(d), 32'h200);
    chk("t2_high_a", h, 512);
    run_period(h, d);
    chk("t2_duty_b", 32'(d), 32'h600);
    chk("t2_high_b", h, 1536);
    chk("t2_no_underrun", 32'(underrun), 0);

    // 3: continuous producer, scoreboard order
    @(negedge clk);
    clr_pulse();
    chk("t3_clr", 32'(underrun), 0);
    data         = 11'h100;
    sample_in    = data;
    sample_valid = 1'b1;
    rdy_prev     = sample_ready;
    prev_tick    = 1'b0;
    ticks        = 0;
    acc_period   = 0;
    guard        = 0;
    while (ticks < 4 && guard < 12000) begin
      @(negedge clk);
      guard++;
      if (rdy_prev) begin
        exp_q.push_back(CW'(data));
        data++;
        acc_period++;
      end
      if (prev_tick) begin
        if (exp_q.size() > 0) begin
          exp_d = exp_q.pop_front();
          chk("t3_sb_duty", 32'(duty_cur), 32'(exp_d));
        end else begin
          chk("t3_sb_empty", 32'(exp_q.size()), 1);
        end
      end
      prev_tick = period_tick;
      if (period_tick) begin
        ticks++;
        chk("t3_full_at_tick", 32'(sample_ready), 0);
        if (ticks > 1) chk("t3_one_per_period", acc_period, 1);
        acc_period = 0;
      end
      rdy_prev  = sample_ready;
      sample_in = data;
    end
    sample_valid = 1'b0;
    chk("t3_ticks", ticks, 4);
    chk("t3_queued", 32'(exp_q.size()), 2);
    chk("t3_no_underrun", 32'(underrun), 0);
    for (int k = 0; k < 2; k++) begin
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      run_period(h, d);
      chk("t3_drain_duty", 32'(d), 32'(exp_d));
      chk("t3_drain_high", h, 32'(exp_d));
      last_d = exp_d;
    end

    // 4: push on an empty boundary; set beats clear
    push(11'h300);
    chk("t4_underrun", 32'(underrun), 1);
    chk("t4_duty_hold", 32'(duty_cur), 32'(last_d));
    chk("t4_ready", 32'(sample_ready), 1);
    clr_pulse();
    chk("t4_clr_mid", 32'(underrun), 0);
    wait_tick("t4_tick");
    chk("t4_duty_before_pop", 32'(duty_cur), 32'(last_d));
    run_period(h, d);
    chk("t4_duty_new", 32'(d), 32'h300);
    chk("t4_high_new", h, 768);
    clr_pulse();
    chk("t4_set_wins", 32'(underrun), 1);
    chk("t4_duty_held", 32'(duty_cur), 32'h300);

    // 5: duty extremes, then enable toggle
    push(11'h000);
    push(11'h7FF);
    wait_tick("t5_tick");
    run_period(h, d);
    chk("t5_duty_zero", 32'(d), 0);
    chk("t5_high_zero", h, 0);
    run_period(h, d);
    chk("t5_duty_max", 32'(d), 2047);
    chk("t5_high_max", h, 2047);
    @(negedge clk);
    push(11'h100);
    push(11'h500);
    chk("t5_full", 32'(sample_ready), 0);
    repeat (100) @(negedge clk);
    chk("t5_pwm_high_mid", 32'(pwm_out), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_pwm_parked", 32'(pwm_out), 0);
    clr_pulse();
    ticks = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (period_tick) ticks++;
    end
    chk("t5_no_tick_disabled", ticks, 0);
    chk("t5_fifo_kept", 32'(sample_ready), 0);
    chk("t5_duty_kept", 32'(duty_cur), 2047);
    chk("t5_no_underrun_disabled", 32'(underrun), 0);
    chk("t5_pwm_low_disabled", 32'(pwm_out), 0);
    enable = 1'b1;
    #1 chk("t5_reenable_tick", 32'(period_tick), 1);
    @(negedge clk);
    chk("t5_reenable_pop", 32'(duty_cur), 32'h100);
    chk("t5_reenable_ready", 32'(sample_ready), 1);
    chk("t5_reenable_underrun", 32'(underrun), 0);

    // 6: asynchronous reset with samples queued
    push(11'h600);
    chk("t6_full", 32'(sample_ready), 0);
    repeat (50) @(negedge clk);
    chk("t6_pwm_high", 32'(pwm_out), 1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("t6_pwm_async_low", 32'(pwm_out), 0);
    chk("t6_duty_async", 32'(duty_cur), 1024);
    chk("t6_ready_async", 32'(sample_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_duty_after", 32'(duty_cur), 1024);
    chk("t6_ready_after", 32'(sample_ready), 1);
    chk("t6_underrun_after", 32'(underrun), 0);
    enable = 1'b1;
    run_period(h, d);
    chk("t6_empty_duty", 32'(d), 1024);
    chk("t6_empty_high", h, 1024);
    chk("t6_empty_underrun", 32'(underrun), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
